serial_subtractor_64_bit: RTL and testbench
===========================================

// Module: serial_subtractor_64_bit
// PURPOSE
//  Multi-cycle 64-bit subtractor: computes A - B - borrow_in one SLICE-bit slice per clock, LSB slice first.
//  Each slice is computed as A + ~B + carry, with carry = ~borrow.
//  Complements the ripple-carry adder datapath: same slice-wise carry chain, run in the subtract direction.
//  Trades latency for area, using a single SLICE-wide adder slice.
//  Sits beside the adder in the ALU; driven by a start/ready/done handshake from the sequencer.
// PARAMETERS
//  WIDTH  64  operand/result width; must be a multiple of SLICE
//  SLICE   8  bits processed per clock; NSLICE = WIDTH/SLICE (default 8)
// PORTS
//  clk         input   1      rising-edge clock
//  reset       input   1      synchronous, active-high reset
//  start       input   1      request; accepted only on an edge where ready=1
//  A           input   WIDTH  minuend; sampled on the accepting edge only
//  B           input   WIDTH  subtrahend; sampled on the accepting edge only
//  borrow_in   input   1      borrow into bit 0; sampled on the accepting edge only
//  ready       output  1      1 in IDLE; can accept start
//  busy        output  1      1 in RUN
//  done        output  1      one-cycle pulse: result valid
//  difference  output  WIDTH  A - B - borrow_in mod 2^WIDTH; held until the next accept
//  borrow_out  output  1      1 when unsigned A < B + borrow_in
//  overflow    output  1      signed overflow: A[msb]!=B[msb] && difference[msb]!=A[msb]
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, ready=1, busy=0, done=0.
//   - difference=0, borrow_out=0, overflow=0, slice counter=0.
//  State machine IDLE -> RUN -> DONE -> IDLE:
//   - IDLE: on an edge with start=1:
//     - latch A and B; set internal carry=~borrow_in; clear the counter;
//     - clear difference, borrow_out and overflow;
//     - go to RUN.
//   - RUN: on each edge, slice k=counter is computed:
//     - difference[k*SLICE +: SLICE] <= A_k + ~B_k + carry;
//     - carry <= slice carry-out; counter++.
//     - After slice NSLICE-1, go to DONE.
//   - DONE: one cycle. done=1, ready=0, busy=0.
//     - borrow_out=~final carry; overflow valid.
//     - Next edge returns to IDLE.
//  Latency:
//   - start accepted on edge E0; slices computed on edges E1..E8.
//   - done high for the cycle after E8; ready returns after E9.
//   - Back-to-back operations repeat every 10 cycles.
//  start while ready=0 is ignored: no queuing, no error; the in-flight operation is unaffected.
//  Operand inputs may change freely after the accepting edge; internal copies are used.
//  Counter wraps only via the RUN->DONE exit; it never exceeds NSLICE-1.
//  difference bits of slices not yet computed read 0 during RUN; software uses them only at done.
//  reset has priority over every other event, including mid-RUN and the DONE cycle:
//   - the operation is aborted;
//   - all outputs go to their reset values on that edge;
//   - ready=1 in the following cycle;
//   - no done pulse is produced for the aborted operation.
//  start and reset together on one edge: reset wins; start is dropped.
// TESTING
//  1. A=5, B=3, bin=0 -> done at E0+9; difference=2, borrow_out=0, overflow=0.
//  2. A=0, B=1, bin=0 -> difference=64'hFFFF_FFFF_FFFF_FFFF, borrow_out=1, overflow=0.
//  3. Cross-slice borrow: A=64'h100, B=0, bin=1 -> difference=64'hFF, borrow_out=0.
//  4. A=64'h8000_0000_0000_0000, B=1, bin=0 -> difference=64'h7FFF_FFFF_FFFF_FFFF, overflow=1, borrow_out=0.
//  5. Pulse start at E0+3 with new operands -> ignored; first result correct; ready=1 only after E9.
//  6. reset on edge E0+4 mid-RUN -> all outputs 0, ready=1 next cycle, no done; a new op completes normally.

Source files
------------

// File: rtl/serial_subtractor_64_bit.sv
// Multi-cycle subtractor: difference = A - B - borrow_in, one SLICE-bit slice per clock, LSB slice first.
// Each slice is A + ~B + carry, where carry starts as ~borrow_in and ripples between clocks.
module serial_subtractor_64_bit #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             borrow_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic [IW-1:0]    slice_base;
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_sum;

  // Single SLICE-wide adder shared by every slice; the counter picks which bits feed it.
  assign slice_base = IW'(cnt_q) * IW'(SLICE);
  assign a_slice    = a_q[slice_base +: SLICE];
  assign b_slice    = b_q[slice_base +: SLICE];
  assign slice_sum  = {1'b0, a_slice} + {1'b0, ~b_slice} + {{SLICE{1'b0}}, carry_q};

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          carry_d  = ~borrow_in;
          cnt_d    = '0;
          diff_d   = '0;
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        diff_d[slice_base +: SLICE] = slice_sum[SLICE-1:0];
        carry_d                     = slice_sum[SLICE];
        if (cnt_q == LAST_SLICE) begin
          // Final slice: its carry-out and sign bit settle the flags held through DONE and beyond.
          cnt_d    = '0;
          borrow_d = ~slice_sum[SLICE];
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                     (slice_sum[SLICE-1] != a_q[WIDTH-1]);
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: operand copies and carry carry no reset; they are always reloaded on accept before use.
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    carry_q <= carry_d;
  end

  assign ready      = (state_q == S_IDLE);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign difference = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_64_bit.sv
// Randomized self-checking bench for serial_subtractor_64_bit against a plain-arithmetic model.
module tb_serial_subtractor_64_bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic        borrow_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] difference;
  logic        borrow_out;
  logic        overflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  serial_subtractor_64_bit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .A          (A),
    .B          (B),
    .borrow_in  (borrow_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one operation from a negedge with ready=1; returns on the negedge after E9.
  // inject_at > 0 pulses start (with junk operands) so that edge E<inject_at> sees it.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                        input int inject_at, input string tag);
    logic [64:0] full;
    logic [63:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;
    logic [63:0] mask;
    logic [2:0]  exp_st;
    int          s;

    full     = {1'b0, a} - {1'b0, b} - {64'd0, bin};
    exp_diff = full[63:0];
    exp_bout = full[64];
    exp_ovf  = (a[63] != b[63]) && (exp_diff[63] != a[63]);

    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pre_ready: got %b want 1", tag, ready);
    end

    A = a; B = b; borrow_in = bin; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start     = (i == inject_at);
      A         = {$urandom, $urandom};
      B         = {$urandom, $urandom};
      borrow_in = 1'($urandom_range(0, 1));

      if (i <= 8)      exp_st = 3'b010;
      else if (i == 9) exp_st = 3'b001;
      else             exp_st = 3'b100;
      n_checks++;
      if ({ready, busy, done} !== exp_st) begin
        n_fail++;
        $display("FAIL %s status@%0d: got rbd=%b want %b", tag, i, {ready, busy, done}, exp_st);
      end

      s    = (i > 8) ? 8 : i - 1;
      mask = (s == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * s)) - 64'd1);
      n_checks++;
      if (difference !== (exp_diff & mask)) begin
        n_fail++;
        $display("FAIL %s diff@%0d: got %h want %h", tag, i, difference, exp_diff & mask);
      end

      n_checks++;
      if ({borrow_out, overflow} !== ((i >= 9) ? {exp_bout, exp_ovf} : 2'b00)) begin
        n_fail++;
        $display("FAIL %s flags@%0d: got bo/ov=%b want %b", tag, i, {borrow_out, overflow},
                 (i >= 9) ? {exp_bout, exp_ovf} : 2'b00);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; A = {$urandom, $urandom}; B = {$urandom, $urandom}; borrow_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready, busy, done, difference, borrow_out, overflow} !== {3'b100, 64'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_values: got rbd=%b diff=%h bo=%b ov=%b want rbd=100 diff=0 bo=0 ov=0",
               {ready, busy, done}, difference, borrow_out, overflow);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ready, busy, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got rbd=%b want 100", {ready, busy, done});
    end
  endtask

  task automatic test_directed();
    run_op(64'd5, 64'd3, 1'b0, 0, "dir_5_minus_3");
    run_op(64'd0, 64'd1, 1'b0, 0, "dir_0_minus_1");
    run_op(64'h100, 64'd0, 1'b1, 0, "dir_cross_slice");
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0, "dir_signed_ovf");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 0, "random");
  endtask

  task automatic test_ignored_start();
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 3, "start_in_run");
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 9, "start_in_done");
  endtask

  task automatic test_back_to_back();
    int unsigned t0;
    t0 = cyc;
    for (int n = 0; n < 4; n++)
      run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 0, "b2b");
    n_checks++;
    if (cyc - t0 !== 32'd40) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d cycles want 40", cyc - t0);
    end
  endtask

  // Reset lands on edge E<at> of an in-flight operation.
  task automatic test_reset_abort(input int at);
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; borrow_in = 1'b0; start = 1'b1;
    for (int i = 1; i <= at; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == at) reset = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if ({ready, busy, done, difference, borrow_out, overflow} !== {3'b100, 64'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL abort@%0d: got rbd=%b diff=%h bo=%b ov=%b want rbd=100 all zero", at,
               {ready, busy, done}, difference, borrow_out, overflow);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ready, done} !== 2'b10) begin
        n_fail++;
        $display("FAIL abort@%0d idle_%0d: got ready/done=%b want 10", at, i, {ready, done});
      end
    end
    run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 0, "after_abort");
  endtask

  task automatic test_start_reset_collision();
    A = 64'd9; B = 64'd4; borrow_in = 1'b0; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    n_checks++;
    if ({ready, busy, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL collision_edge: got rbd=%b want 100", {ready, busy, done});
    end
    @(negedge clk);
    n_checks++;
    if ({ready, busy, done, difference} !== {3'b100, 64'h0}) begin
      n_fail++;
      $display("FAIL collision_after: got rbd=%b diff=%h want 100 diff=0", {ready, busy, done}, difference);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; borrow_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort(4);
    test_reset_abort(9);
    test_start_reset_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
